// File: rtl/synth_pkg.sv
// Shared constants for the synth datapath: PS/2 prefix bytes, the note-key table
// and the scan-code parser states. The tone-table stage also imports this package.
package synth_pkg;

   localparam logic [7:0] KEY_BREAK  = 8'hF0;
   localparam logic [7:0] KEY_EXT    = 8'hE0;
   localparam int         NUM_VOICES = 4;
   localparam int         NUM_NOTES  = 20;

   localparam logic [7:0] NOTE_CODES [NUM_NOTES] = '{
      8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
      8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B
   };

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BRK     = 2'd1,
      S_EXT     = 2'd2,
      S_EXT_BRK = 2'd3
   } parse_state_t;

   function automatic logic is_note(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (NOTE_CODES[i] == code) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/voice_lru.sv
// Allocation-age ranks for the voice bank: 0 = newest, rank 3 = oldest once the
// bank is full. Ranks of busy voices stay a permutation of 0..busy_count-1.
module voice_lru (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       alloc_en,
   input  logic [1:0] alloc_idx,
   input  logic [3:0] release_mask,
   input  logic [3:0] busy,
   output logic [1:0] oldest_idx,
   output logic [7:0] ranks
);
   import synth_pkg::*;

   logic [1:0] rank_q [NUM_VOICES];
   logic [1:0] drop   [NUM_VOICES];

   // A surviving voice moves up by one for every released voice that was newer.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         drop[i] = 2'd0;
         for (int j = 0; j < NUM_VOICES; j++) begin
            if (release_mask[j] && busy[j] && (rank_q[j] < rank_q[i])) drop[i] = drop[i] + 2'd1;
         end
      end
   end

   always_comb begin
      oldest_idx = 2'd0;
      ranks      = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (rank_q[i] == 2'd3) oldest_idx = 2'(i);
         ranks[2*i +: 2] = rank_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= 2'd0;
      end else if (alloc_en) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc_idx == 2'(i)) rank_q[i] <= 2'd0;
            else if (busy[i])       rank_q[i] <= rank_q[i] + 2'd1;
         end
      end else if (|release_mask) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (release_mask[i]) rank_q[i] <= 2'd0;
            else if (busy[i])    rank_q[i] <= rank_q[i] - drop[i];
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Four-voice note allocator: parses the PS/2 byte stream and maps held note keys
// onto channel registers, stealing the oldest voice when the bank is full.
module voice_allocator #(
   parameter bit STEAL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_ready,
   input  logic       all_off,
   output logic [7:0] scan_code1,
   output logic [7:0] scan_code2,
   output logic [7:0] scan_code3,
   output logic [7:0] scan_code4,
   output logic [3:0] voice_busy,
   output logic       steal,
   output logic [1:0] parser_state,
   output logic [7:0] lru_ranks
);
   import synth_pkg::*;

   // scan_ready is a one-cycle valid strobe with no ready/backpressure: every
   // strobed byte is consumed on that edge unless all_off discards it.
   parse_state_t          state, state_next;
   logic [7:0]            code_q    [NUM_VOICES];
   logic [7:0]            code_next [NUM_VOICES];
   logic [NUM_VOICES-1:0] busy_q, hit_mask, release_mask;
   logic                  make_ev, brk_ev, any_free, alloc_en, steal_next;
   logic [1:0]            free_idx, oldest_idx, alloc_idx;

   always_comb begin
      state_next = state;
      make_ev    = 1'b0;
      brk_ev     = 1'b0;
      if (scan_ready) begin
         case (state)
            S_IDLE: begin
               if (scan_code == KEY_BREAK)    state_next = S_BRK;
               else if (scan_code == KEY_EXT) state_next = S_EXT;
               else                           make_ev    = is_note(scan_code);
            end
            S_BRK: begin
               if (scan_code == KEY_EXT) state_next = S_EXT_BRK;
               else if (scan_code != KEY_BREAK) begin
                  brk_ev     = is_note(scan_code);
                  state_next = S_IDLE;
               end
            end
            S_EXT:     state_next = (scan_code == KEY_BREAK) ? S_EXT_BRK : S_IDLE;
            S_EXT_BRK: state_next = S_IDLE;
            default:   state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      free_idx = 2'd0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         hit_mask[i] = busy_q[i] && (code_q[i] == scan_code);
         if (!busy_q[i]) free_idx = 2'(i);
      end
      any_free = ~&busy_q;
   end

   // A repeat of a held key never reallocates; a full bank either steals or drops.
   always_comb begin
      alloc_en   = 1'b0;
      alloc_idx  = free_idx;
      steal_next = 1'b0;
      if (make_ev && (hit_mask == '0)) begin
         if (any_free) begin
            alloc_en = 1'b1;
         end else if (STEAL_EN) begin
            alloc_en   = 1'b1;
            alloc_idx  = oldest_idx;
            steal_next = 1'b1;
         end
      end
      release_mask = brk_ev ? hit_mask : '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         code_next[i] = code_q[i];
         if (release_mask[i])                     code_next[i] = KEY_BREAK;
         if (alloc_en && (alloc_idx == 2'(i)))    code_next[i] = scan_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || all_off) begin
         state  <= S_IDLE;
         steal  <= 1'b0;
         busy_q <= '0;
         for (int i = 0; i < NUM_VOICES; i++) code_q[i] <= KEY_BREAK;
      end else begin
         state <= state_next;
         steal <= steal_next;
         for (int i = 0; i < NUM_VOICES; i++) begin
            code_q[i] <= code_next[i];
            busy_q[i] <= (code_next[i] != KEY_BREAK);
         end
      end
   end

   voice_lru u_lru (
      .clk          (clk),
      .reset        (reset),
      .clear        (all_off),
      .alloc_en     (alloc_en),
      .alloc_idx    (alloc_idx),
      .release_mask (release_mask),
      .busy         (busy_q),
      .oldest_idx   (oldest_idx),
      .ranks        (lru_ranks)
   );

   assign scan_code1   = code_q[0];
   assign scan_code2   = code_q[1];
   assign scan_code3   = code_q[2];
   assign scan_code4   = code_q[3];
   assign voice_busy   = busy_q;
   assign parser_state = state;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, hand-written corner sequences
// and random byte streams checked against an allocation-order reference model.
module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] scan_code = 8'h00;
   logic       scan_ready = 1'b0;
   logic       all_off = 1'b0;
   logic [7:0] scan_code1, scan_code2, scan_code3, scan_code4;
   logic [3:0] voice_busy;
   logic       steal;
   logic [1:0] parser_state;
   logic [7:0] lru_ranks;

   always #5 clk = ~clk;

   voice_allocator #(.STEAL_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .scan_code    (scan_code),
      .scan_ready   (scan_ready),
      .all_off      (all_off),
      .scan_code1   (scan_code1),
      .scan_code2   (scan_code2),
      .scan_code3   (scan_code3),
      .scan_code4   (scan_code4),
      .voice_busy   (voice_busy),
      .steal        (steal),
      .parser_state (parser_state),
      .lru_ranks    (lru_ranks)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  code;
      bit          off;
      logic [31:0] codes;
      logic [3:0]  busy;
      bit          st;
   } vec_t;
   vec_t vecs[$];

   logic [7:0] notes [20] = '{
      8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
      8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B
   };

   // Reference model: voices as an array, age as a queue of voice indices in
   // allocation order (front = oldest), prefix bytes as two pending flags.
   logic [7:0] m_code [4];
   int         m_order[$];
   bit         m_brk, m_ext, m_steal;

   function automatic bit m_is_note(input logic [7:0] b);
      for (int i = 0; i < 20; i++) if (notes[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int v = 0; v < 4; v++) m_code[v] = 8'hF0;
      m_order.delete();
      m_brk = 0; m_ext = 0; m_steal = 0;
   endtask

   task automatic m_make(input logic [7:0] b);
      int victim;
      for (int v = 0; v < 4; v++) if (m_code[v] == b) return;
      for (int v = 0; v < 4; v++) begin
         if (m_code[v] == 8'hF0) begin
            m_code[v] = b;
            m_order.push_back(v);
            return;
         end
      end
      victim = m_order.pop_front();
      m_code[victim] = b;
      m_order.push_back(victim);
      m_steal = 1;
   endtask

   task automatic m_break(input logic [7:0] b);
      for (int v = 0; v < 4; v++) begin
         if (m_code[v] == b) begin
            m_code[v] = 8'hF0;
            for (int k = 0; k < m_order.size(); k++) begin
               if (m_order[k] == v) begin
                  m_order.delete(k);
                  break;
               end
            end
         end
      end
   endtask

   task automatic m_byte(input logic [7:0] b, input bit off);
      m_steal = 0;
      if (off) begin
         m_clear();
      end else if (m_ext) begin
         if (!m_brk && b == 8'hF0) m_brk = 1;
         else begin m_ext = 0; m_brk = 0; end
      end else if (m_brk) begin
         if (b == 8'hE0) m_ext = 1;
         else if (b != 8'hF0) begin
            m_brk = 0;
            if (m_is_note(b)) m_break(b);
         end
      end else begin
         if (b == 8'hF0)      m_brk = 1;
         else if (b == 8'hE0) m_ext = 1;
         else if (m_is_note(b)) m_make(b);
      end
   endtask

   function automatic logic [31:0] m_codes();
      return {m_code[0], m_code[1], m_code[2], m_code[3]};
   endfunction

   function automatic logic [3:0] m_busy();
      logic [3:0] b;
      for (int v = 0; v < 4; v++) b[v] = (m_code[v] != 8'hF0);
      return b;
   endfunction

   function automatic logic [7:0] m_ranks();
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < m_order.size(); k++) r[2*m_order[k] +: 2] = 2'(m_order.size() - 1 - k);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_codes"}, {scan_code1, scan_code2, scan_code3, scan_code4}, m_codes());
      check({tag, "_busy"},  32'(voice_busy), 32'(m_busy()));
      check({tag, "_steal"}, 32'(steal), 32'(m_steal));
      check({tag, "_ranks"}, 32'(lru_ranks), 32'(m_ranks()));
   endtask

   task automatic send(input logic [7:0] b, input bit off);
      @(negedge clk);
      scan_code  = b;
      scan_ready = 1'b1;
      all_off    = off;
      @(negedge clk);
      scan_ready = 1'b0;
      all_off    = 1'b0;
      m_byte(b, off);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_clear();
   endtask

   task automatic add(input logic [7:0] code, input bit off, input logic [31:0] codes,
                      input logic [3:0] busy, input bit st);
      vec_t v;
      v.code = code; v.off = off; v.codes = codes; v.busy = busy; v.st = st;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] b;
      int r;

      add(8'h1C, 0, 32'h1CF0F0F0, 4'b0001, 0);
      add(8'h1B, 0, 32'h1C1BF0F0, 4'b0011, 0);
      add(8'h23, 0, 32'h1C1B23F0, 4'b0111, 0);
      add(8'h2B, 0, 32'h1C1B232B, 4'b1111, 0);
      add(8'h34, 0, 32'h341B232B, 4'b1111, 1);
      add(8'h33, 0, 32'h3433232B, 4'b1111, 1);
      add(8'h33, 0, 32'h3433232B, 4'b1111, 0);
      add(8'hF0, 0, 32'h3433232B, 4'b1111, 0);
      add(8'h33, 0, 32'h34F0232B, 4'b1101, 0);
      add(8'h42, 0, 32'h3442232B, 4'b1111, 0);
      add(8'h44, 0, 32'h3442442B, 4'b1111, 1);
      add(8'hE0, 0, 32'h3442442B, 4'b1111, 0);
      add(8'h1C, 0, 32'h3442442B, 4'b1111, 0);
      add(8'hE0, 0, 32'h3442442B, 4'b1111, 0);
      add(8'hF0, 0, 32'h3442442B, 4'b1111, 0);
      add(8'h2B, 0, 32'h3442442B, 4'b1111, 0);
      add(8'h29, 0, 32'h3442442B, 4'b1111, 0);
      add(8'hF0, 0, 32'h3442442B, 4'b1111, 0);
      add(8'h29, 0, 32'h3442442B, 4'b1111, 0);
      add(8'h42, 1, 32'hF0F0F0F0, 4'b0000, 0);
      add(8'h42, 0, 32'h42F0F0F0, 4'b0001, 0);
      add(8'hF0, 0, 32'h42F0F0F0, 4'b0001, 0);
      add(8'hF0, 0, 32'h42F0F0F0, 4'b0001, 0);
      add(8'h42, 0, 32'hF0F0F0F0, 4'b0000, 0);
      add(8'h4D, 0, 32'h4DF0F0F0, 4'b0001, 0);
      add(8'h1B, 0, 32'h4D1BF0F0, 4'b0011, 0);
      add(8'h23, 0, 32'h4D1B23F0, 4'b0111, 0);
      add(8'hF0, 0, 32'h4D1B23F0, 4'b0111, 0);
      add(8'h1B, 0, 32'h4DF023F0, 4'b0101, 0);
      add(8'h2B, 0, 32'h4D2B23F0, 4'b0111, 0);
      add(8'h34, 0, 32'h4D2B2334, 4'b1111, 0);
      add(8'h35, 0, 32'h352B2334, 4'b1111, 1);
      add(8'hE0, 0, 32'h352B2334, 4'b1111, 0);
      add(8'hF0, 0, 32'h352B2334, 4'b1111, 0);
      add(8'hF0, 0, 32'h352B2334, 4'b1111, 0);
      add(8'h1C, 0, 32'h352B1C34, 4'b1111, 1);
      add(8'hE0, 0, 32'h352B1C34, 4'b1111, 0);
      add(8'hE0, 0, 32'h352B1C34, 4'b1111, 0);
      add(8'h15, 0, 32'h35151C34, 4'b1111, 1);

      m_clear();
      do_reset();
      check("rst_codes", {scan_code1, scan_code2, scan_code3, scan_code4}, 32'hF0F0F0F0);
      check("rst_busy", 32'(voice_busy), 32'h0);
      check("rst_steal", 32'(steal), 32'h0);
      check("rst_state", 32'(parser_state), 32'h0);
      check("rst_ranks", 32'(lru_ranks), 32'h0);

      foreach (vecs[i]) begin
         send(vecs[i].code, vecs[i].off);
         check($sformatf("tbl%0d_codes", i), {scan_code1, scan_code2, scan_code3, scan_code4}, vecs[i].codes);
         check($sformatf("tbl%0d_busy", i), 32'(voice_busy), 32'(vecs[i].busy));
         check($sformatf("tbl%0d_steal", i), 32'(steal), 32'(vecs[i].st));
         check($sformatf("tbl%0d_ranks", i), 32'(lru_ranks), 32'(m_ranks()));
      end

      // steal is a single-cycle pulse
      @(negedge clk);
      check("steal_one_cycle", 32'(steal), 32'h0);

      // typematic repeat of a held key uses one voice only
      do_reset();
      for (int k = 0; k < 5; k++) begin
         send(8'h1C, 0);
         check("repeat_codes", {scan_code1, scan_code2, scan_code3, scan_code4}, 32'h1CF0F0F0);
         check("repeat_steal", 32'(steal), 32'h0);
      end
      send(8'hF0, 0);
      send(8'h1C, 0);
      check("repeat_release", 32'(voice_busy), 32'h0);

      // reset in the middle of a break prefix: the next byte is a make
      send(8'hF0, 0);
      do_reset();
      check("midrst_state", 32'(parser_state), 32'h0);
      send(8'h1C, 0);
      check("midrst_make", 32'(scan_code1), 32'h1C);

      // random byte streams
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         if (r < 50)      b = notes[$urandom_range(0, 7)];
         else if (r < 62) b = notes[$urandom_range(0, 19)];
         else if (r < 78) b = 8'hF0;
         else if (r < 86) b = 8'hE0;
         else             b = 8'($urandom_range(0, 255));
         send(b, ($urandom_range(0, 99) < 2));
         check_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Four-voice note allocator between the PS/2 keyboard decoder and the staff/tone-generator stage.
- Parses the raw scan-code byte stream (make, F0 break, E0 extended prefixes) and assigns each held note key to one of four channel registers.
- When all voices are busy, steals the least-recently-allocated voice.
- Channel register value 8'hF0 means "voice silent", which the downstream sound_off logic already decodes.

Parameters:
- NUM_VOICES, 4, number of channel registers; fixed at 4 in this revision.
- STEAL_EN, 1, 1 = steal the oldest voice when all are busy; 0 = drop the new note.

Ports:
- clk  input  1  system clock, same domain as the PS/2 decoder output.
- reset  input  1  synchronous, active-high.
- scan_code  input  8  byte from PS/2 decoder.
- scan_ready  input  1  one-cycle strobe; scan_code is valid this cycle.
- all_off  input  1  synchronous panic: silence all voices.
- scan_code1, scan_code2, scan_code3, scan_code4  output  8 each  per-voice key code; 8'hF0 = off.
- voice_busy  output  4  bit n = 1 when voice n+1 holds a note.
- steal  output  1  one-cycle pulse when a voice was stolen.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous, active-high. All state is registered on clk.
- Reset values: scan_code1..4 = 8'hF0, voice_busy = 0, steal = 0, parser in S_IDLE, all LRU ranks = 0.
- Latency: an accepted byte updates the outputs on the clock edge after scan_ready. steal is asserted in that same cycle, for one cycle only.
- Parser FSM (advances only on scan_ready):
  - S_IDLE: F0 -> S_BRK; E0 -> S_EXT; any other byte -> make event, stay.
  - S_BRK: F0 -> stay; E0 -> S_EXT_BRK; other -> break event, -> S_IDLE.
  - S_EXT: F0 -> S_EXT_BRK; other -> discard, -> S_IDLE.
  - S_EXT_BRK: any byte -> discard, -> S_IDLE.
- Note filter: only the 20 note codes in the package table generate events. Codes: 15 1C 1D 1B 24 23 2B 2C 34 35 33 3B 43 42 44 4B 4D 4C 52 5B. Non-note make and break codes are ignored; the parser still advances.
- Make event, priority order:
  1. Code already held by any voice (typematic repeat): no change.
  2. Else, if any voice is free: the lowest-index free voice takes the code.
  3. Else, if STEAL_EN = 1: the voice with rank 3 takes the code and steal pulses.
  4. Else: drop the note.
- Break event: every voice holding that code -> 8'hF0. A break for a code held nowhere is a no-op.
- LRU ranks (2 bits per voice, distinct among busy voices, 0 = newest):
  - Allocate to a free voice: every busy voice rank +1; new voice rank 0.
  - Steal: every other voice rank +1; stolen voice rank 0.
  - Release of rank r: busy voices with rank > r take rank -1; released voice rank cleared to 0.
  - Busy-voice ranks are always a permutation of 0..(busy count - 1).
- all_off: all voices -> 8'hF0, ranks -> 0, parser -> S_IDLE, steal = 0. all_off wins over a simultaneous scan_ready, and that byte is discarded.
- reset asserted mid-sequence (e.g. after F0) returns the parser to S_IDLE; the next byte is treated as a make.
- voice_busy[n] is equivalent to (scan_code(n+1) != 8'hF0), registered alongside it.

Decomposition:
- Shared package synth_pkg:
  - KEY_BREAK = 8'hF0, KEY_EXT = 8'hE0, NUM_VOICES = 4.
  - The 20-entry note code table and a function is_note(code).
  - Parser state enum.
  - The tone-table stage imports this package later.
- One sub-module voice_lru: holds the 4 rank registers.
  - Inputs: alloc_idx/alloc_en, release_mask, clear.
  - Outputs: oldest_idx, plus the ranks for debug.
- Parser, free-voice priority encoder and channel registers stay in voice_allocator.

Test Plan:
- Reset, then byte 1C -> scan_code1 = 1C one cycle later; voice_busy = 0001; scan_code2..4 = F0.
- Bytes 1C, 1B, 23, 2B, 34 -> voices 1..4 hold 1C/1B/23/2B. On 34: scan_code1 = 34 and steal pulses for one cycle. Next distinct make (e.g. 33) replaces voice 2 (1B).
- Make 1C repeated 5 times while held -> only voice 1 used, no steal. Then F0 1C -> scan_code1 = F0, voice_busy = 0000.
- Hold 1C, 1B, 23; break 1B -> voice 2 = F0. New make 2B -> lands in voice 2; the next steal after the bank fills targets voice 1.
- Byte sequences E0 1C and E0 F0 1C -> no output change. Then 4D -> voice 1 = 4D. Byte 29 (non-note) -> no change.
- Voices full; all_off asserted in the same cycle as scan_ready with 42 -> all voices F0, 42 discarded, steal = 0. Next byte 42 -> voice 1 = 42.
